// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch requester, data requester and the shared memory port.
// master = arbiter side, slave = requesters/memory side.
interface mem_arbiter_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              ma_i_if_syn;
    logic [AWIDTH-1:0] ma_i_if_addr;
    logic              ma_i_if_flush;
    logic              ma_o_if_ack;
    logic [DWIDTH-1:0] ma_o_if_rdata;
    logic              ma_o_if_stall;

    logic              ma_i_ds_syn;
    logic              ma_i_ds_we;
    logic [AWIDTH-1:0] ma_i_ds_addr;
    logic [DWIDTH-1:0] ma_i_ds_wdata;
    logic              ma_o_ds_ack;
    logic [DWIDTH-1:0] ma_o_ds_rdata;

    logic              ma_o_mem_syn;
    logic              ma_o_mem_we;
    logic [AWIDTH-1:0] ma_o_mem_addr;
    logic [DWIDTH-1:0] ma_o_mem_wdata;
    logic              ma_i_mem_ack;
    logic [DWIDTH-1:0] ma_i_mem_rdata;

    modport master (
        input  ma_i_if_syn, ma_i_if_addr, ma_i_if_flush,
        output ma_o_if_ack, ma_o_if_rdata, ma_o_if_stall,
        input  ma_i_ds_syn, ma_i_ds_we, ma_i_ds_addr, ma_i_ds_wdata,
        output ma_o_ds_ack, ma_o_ds_rdata,
        output ma_o_mem_syn, ma_o_mem_we, ma_o_mem_addr, ma_o_mem_wdata,
        input  ma_i_mem_ack, ma_i_mem_rdata
    );

    modport slave (
        output ma_i_if_syn, ma_i_if_addr, ma_i_if_flush,
        input  ma_o_if_ack, ma_o_if_rdata, ma_o_if_stall,
        output ma_i_ds_syn, ma_i_ds_we, ma_i_ds_addr, ma_i_ds_wdata,
        input  ma_o_ds_ack, ma_o_ds_rdata,
        input  ma_o_mem_syn, ma_o_mem_we, ma_o_mem_addr, ma_o_mem_wdata,
        output ma_i_mem_ack, ma_i_mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single syn/ack memory port. Define ROUND_ROBIN_EN for
// alternating tie-break; otherwise data always wins a tie.
module mem_arbiter #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input logic           ma_clk,
    input logic           ma_rst,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

    state_t state, state_next;

    logic              mem_syn;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic              if_ack;
    logic              ds_ack;
    logic [DWIDTH-1:0] if_rdata;
    logic [DWIDTH-1:0] ds_rdata;
    logic              drop;
    logic              if_req;
    logic              ds_req;
    logic              pick_d;

    // A requester whose ack is showing this cycle still holds syn for the
    // transaction just finished; masking it here prevents a duplicate grant.
    assign if_req = bus.ma_i_if_syn & ~if_ack;
    assign ds_req = bus.ma_i_ds_syn & ~ds_ack;

`ifdef ROUND_ROBIN_EN
    logic last_d;

    assign pick_d = ds_req & (~if_req | ~last_d);

    always_ff @(posedge ma_clk) begin
        if (ma_rst) begin
            last_d <= 1'b1;
        end else if (state == IDLE) begin
            if (pick_d) begin
                last_d <= 1'b1;
            end else if (if_req) begin
                last_d <= 1'b0;
            end
        end
    end
`else
    assign pick_d = ds_req;
`endif

    always_ff @(posedge ma_clk) begin
        if (ma_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pick_d) begin
                    state_next = GRANT_D;
                end else if (if_req) begin
                    state_next = GRANT_I;
                end
            end
            GRANT_I: begin
                if (bus.ma_i_mem_ack) begin
                    state_next = IDLE;
                end
            end
            GRANT_D: begin
                if (bus.ma_i_mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ma_clk) begin
        if (ma_rst) begin
            mem_syn   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            ds_ack    <= 1'b0;
            if_rdata  <= '0;
            ds_rdata  <= '0;
            drop      <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            ds_ack <= 1'b0;
            case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (pick_d) begin
                        mem_syn   <= 1'b1;
                        mem_we    <= bus.ma_i_ds_we;
                        mem_addr  <= bus.ma_i_ds_addr;
                        mem_wdata <= bus.ma_i_ds_wdata;
                    end else if (if_req) begin
                        mem_syn  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= bus.ma_i_if_addr;
                    end
                end
                GRANT_I: begin
                    if (bus.ma_i_mem_ack) begin
                        mem_syn <= 1'b0;
                        // A flush in the completing cycle also discards the result.
                        if (!(drop || bus.ma_i_if_flush)) begin
                            if_ack   <= 1'b1;
                            if_rdata <= bus.ma_i_mem_rdata;
                        end
                    end else if (bus.ma_i_if_flush) begin
                        drop <= 1'b1;
                    end
                end
                GRANT_D: begin
                    if (bus.ma_i_mem_ack) begin
                        mem_syn <= 1'b0;
                        mem_we  <= 1'b0;
                        ds_ack  <= 1'b1;
                        if (!mem_we) begin
                            ds_rdata <= bus.ma_i_mem_rdata;
                        end
                    end
                end
                default: begin
                    mem_syn <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ma_o_mem_syn   = mem_syn;
    assign bus.ma_o_mem_we    = mem_we;
    assign bus.ma_o_mem_addr  = mem_addr;
    assign bus.ma_o_mem_wdata = mem_wdata;
    assign bus.ma_o_if_ack    = if_ack;
    assign bus.ma_o_if_rdata  = if_rdata;
    assign bus.ma_o_ds_ack    = ds_ack;
    assign bus.ma_o_ds_rdata  = ds_rdata;
    // Gated by reset so the stall output is also low while reset is held.
    assign bus.ma_o_if_stall  = bus.ma_i_if_syn & ~if_ack & ~ma_rst;
endmodule
